// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer states and unit-latency lookup for the
// execute-stage issue controller.
package alu_pkg;

  localparam int NUM_UNITS = 7;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Execute latency in cycles; single-cycle for everything except MUL/DIV.
  function automatic int lat_of(input int op, input int mul_lat, input int div_lat);
    if (op == int'(OP_MUL)) return mul_lat;
    if (op == int'(OP_DIV)) return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/exec_lat_counter.sv
// Down-counter that times the execute phase: loaded with latency-1, flags zero
// in the cycle the selected unit's result is valid.
module exec_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts one instruction, reads its operands, drives
// exactly one functional unit for its fixed latency, then writes back once.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int RA       = 3,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [SEL_LINE-1:0]  opcode,
  input  logic [RA-1:0]        rs1_addr,
  input  logic [RA-1:0]        rs2_addr,
  input  logic [RA-1:0]        rd_addr,
  output logic [RA-1:0]        rf_raddr1,
  output logic [RA-1:0]        rf_raddr2,
  input  logic [N-1:0]         rf_rdata1,
  input  logic [N-1:0]         rf_rdata2,
  output logic [NUM_UNITS-1:0] unit_sel,
  output logic [N-1:0]         op_a,
  output logic [N-1:0]         op_b,
  output logic                 op_start,
  input  logic [N-1:0]         alu_result,
  output logic                 wb_en,
  output logic [RA-1:0]        wb_addr,
  output logic [N-1:0]         wb_data,
  output logic                 busy,
  output logic                 illegal_op,
  output logic                 div_by_zero
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t                 state_reg, state_next;
  logic [SEL_LINE-1:0]    opcode_reg;
  logic [RA-1:0]          rd_reg, raddr1_reg, raddr2_reg;
  logic                   accept, legal_in, legal_reg, div_zero;
  logic                   cnt_load, cnt_zero;
  logic [CW-1:0]          cnt_val;
  logic [NUM_UNITS-1:0]   unit_dec;

  assign instr_ready = (state_reg == IDLE);
  assign busy        = ~instr_ready;
  assign accept      = instr_valid & instr_ready;
  assign legal_in    = (opcode < SEL_LINE'(NUM_UNITS));
  assign legal_reg   = (opcode_reg < SEL_LINE'(NUM_UNITS));
  assign div_zero    = (opcode_reg == SEL_LINE'(OP_DIV)) && (rf_rdata2 == '0);

  // The register file reads synchronously, so the address must be on the port
  // during the accept cycle itself; afterwards it holds the latched index.
  assign rf_raddr1 = accept ? rs1_addr : raddr1_reg;
  assign rf_raddr2 = accept ? rs2_addr : raddr2_reg;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit_dec
      assign unit_dec[gi] = (opcode_reg == SEL_LINE'(gi));
    end
  endgenerate

  assign cnt_load = (state_reg == READ);
  assign cnt_val  = CW'(lat_of(int'(opcode_reg), MUL_LAT, DIV_LAT) - 1);

  exec_lat_counter #(
    .W(CW)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = READ;
      READ: begin
        if (!legal_reg)    state_next = IDLE;
        else if (div_zero) state_next = WB;
        else               state_next = EXEC;
      end
      EXEC: if (cnt_zero) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_reg  <= '0;
      rd_reg      <= '0;
      raddr1_reg  <= '0;
      raddr2_reg  <= '0;
      unit_sel    <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_start    <= 1'b0;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal_op  <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      op_start    <= 1'b0;
      wb_en       <= 1'b0;
      illegal_op  <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        opcode_reg <= opcode;
        rd_reg     <= rd_addr;
        raddr1_reg <= rs1_addr;
        raddr2_reg <= rs2_addr;
        // Flagged during READ so the rejection is visible one cycle after accept.
        illegal_op <= ~legal_in;
      end
      case (state_reg)
        READ: begin
          if (legal_reg) begin
            op_a <= rf_rdata1;
            op_b <= rf_rdata2;
            if (div_zero) begin
              wb_en       <= 1'b1;
              wb_addr     <= rd_reg;
              wb_data     <= '1;
              div_by_zero <= 1'b1;
            end else begin
              unit_sel <= unit_dec;
              op_start <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            wb_en    <= 1'b1;
            wb_addr  <= rd_reg;
            wb_data  <= alu_result;
            unit_sel <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
